move_check_engine: RTL and testbench

Parametrised successor to the per-piece validator mux: one sequential engine that checks a requested chess move for every piece type. It decodes geometry, walks the path through board memory with a configurable read latency, and checks the destination square. Results are registered and held, with a reject reason. It sits between the game-control FSM and the board RAM, and owns the RAM read port while busy.

---
 rtl/chess_pkg.sv | 53 +++++
 rtl/move_geometry.sv | 97 +++++++++
 rtl/move_check_engine.sv | 195 +++++++++++++++++++
 tb/tb_move_check_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the chess move checker: piece codes, colour helpers,
// reject codes, pawn move classes and the checker FSM encoding.
// Purely declarative; no logic, no latency, no flow control.
package chess_pkg;

    // Piece codes: 0 empty, 1..6 white, 7..12 black (pawn, knight, bishop, rook, queen, king)
    localparam int P_EMPTY  = 0;
    localparam int W_PAWN   = 1;
    localparam int W_KNIGHT = 2;
    localparam int W_BISHOP = 3;
    localparam int W_ROOK   = 4;
    localparam int W_QUEEN  = 5;
    localparam int W_KING   = 6;
    localparam int B_PAWN   = 7;
    localparam int B_KNIGHT = 8;
    localparam int B_BISHOP = 9;
    localparam int B_ROOK   = 10;
    localparam int B_QUEEN  = 11;
    localparam int B_KING   = 12;

    localparam logic [2:0] REJ_OK     = 3'd0;
    localparam logic [2:0] REJ_NULL   = 3'd1;
    localparam logic [2:0] REJ_GEOM   = 3'd2;
    localparam logic [2:0] REJ_BLOCK  = 3'd3;
    localparam logic [2:0] REJ_FRIEND = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_PROBE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PM_NONE = 2'd0,
        PM_FWD1 = 2'd1,
        PM_FWD2 = 2'd2,
        PM_DIAG = 2'd3
    } pawn_mode_t;

    function automatic bit is_white(input int p);
        return (p >= W_PAWN) && (p <= W_KING);
    endfunction

    function automatic bit is_black(input int p);
        return (p >= B_PAWN) && (p <= B_KING);
    endfunction

    function automatic bit same_colour(input int a, input int b);
        return (is_white(a) && is_white(b)) || (is_black(a) && is_black(b));
    endfunction

endpackage

// File: rtl/move_geometry.sv
// Move geometry decoder: classifies a latched request as null, illegal or legal
// and yields the walk step (sx, sy), pawn move class and number of squares k to probe.
// Purely combinational; no flow control.
// Ports: piece/org_*/dst_* request in; null_req, legal, pawn_mode, sx, sy (2-bit two's complement), k out.
module move_geometry
    import chess_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int PIECE_W = 4
)(
    input  logic [PIECE_W-1:0] piece,
    input  logic [COORD_W-1:0] org_x,
    input  logic [COORD_W-1:0] org_y,
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    output logic               null_req,
    output logic               legal,
    output pawn_mode_t         pawn_mode,
    output logic [1:0]         sx,
    output logic [1:0]         sy,
    output logic [COORD_W-1:0] k
);
    localparam logic [COORD_W-1:0] W_HOME = COORD_W'(1);
    localparam logic [COORD_W-1:0] B_HOME = COORD_W'((1 << COORD_W) - 2);
    localparam logic [COORD_W:0]   D0     = '0;
    localparam logic [COORD_W:0]   D1     = (COORD_W+1)'(1);
    localparam logic [COORD_W:0]   D2     = (COORD_W+1)'(2);

    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W:0]        adx, ady, dmax;
    logic                    dy_pos, dy_neg, straight, diagonal;
    int                      pc;

    always_comb begin
        pc       = int'(piece);
        dx       = $signed({1'b0, dst_x}) - $signed({1'b0, org_x});
        dy       = $signed({1'b0, dst_y}) - $signed({1'b0, org_y});
        adx      = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        ady      = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        dmax     = (adx > ady) ? adx : ady;
        dy_pos   = !dy[COORD_W] && (ady != D0);
        dy_neg   = dy[COORD_W];
        straight = (adx == D0) != (ady == D0);
        diagonal = (adx == ady) && (adx != D0);
        sx       = (adx == D0) ? 2'b00 : (dx[COORD_W] ? 2'b11 : 2'b01);
        sy       = (ady == D0) ? 2'b00 : (dy[COORD_W] ? 2'b11 : 2'b01);
        null_req = ((org_x == dst_x) && (org_y == dst_y)) || (pc == P_EMPTY) || (pc > B_KING);

        legal     = 1'b0;
        pawn_mode = PM_NONE;
        k         = '0;
        if (!null_req) begin
            case (pc)
                W_KNIGHT, B_KNIGHT: begin
                    legal = ((adx == D1) && (ady == D2)) || ((adx == D2) && (ady == D1));
                    k     = COORD_W'(1);
                end
                W_KING, B_KING: begin
                    legal = (dmax == D1);
                    k     = COORD_W'(1);
                end
                W_ROOK, B_ROOK: begin
                    legal = straight;
                    k     = dmax[COORD_W-1:0];
                end
                W_BISHOP, B_BISHOP: begin
                    legal = diagonal;
                    k     = dmax[COORD_W-1:0];
                end
                W_QUEEN, B_QUEEN: begin
                    legal = straight || diagonal;
                    k     = dmax[COORD_W-1:0];
                end
                W_PAWN, B_PAWN: begin
                    // Forward direction and home row depend on colour.
                    if ((pc == W_PAWN) ? dy_pos : dy_neg) begin
                        if ((adx == D0) && (ady == D1)) begin
                            pawn_mode = PM_FWD1;
                        end else if ((adx == D0) && (ady == D2) &&
                                     (org_y == ((pc == W_PAWN) ? W_HOME : B_HOME))) begin
                            pawn_mode = PM_FWD2;
                        end else if ((adx == D1) && (ady == D1)) begin
                            pawn_mode = PM_DIAG;
                        end
                    end
                    legal = (pawn_mode != PM_NONE);
                    k     = (pawn_mode == PM_FWD2) ? COORD_W'(2) : COORD_W'(1);
                end
                default: ;
            endcase
            if (!legal) begin
                k = '0;
            end
        end
    end

endmodule

// File: rtl/move_check_engine.sv
// Sequential chess move checker: decodes the move, walks the path through board RAM, checks the destination.
// Latency: result 1 + (squares probed) * MEM_LAT cycles after the accepted start edge; result held until next start.
// No backpressure: start is ignored while busy; abort cancels from any non-idle state in one cycle.
// Ports: clk, reset (async high); start/abort; request piece_to_move, origin_*, destination_*;
//        RAM read via address_validator/piece_read; status busy, validate_complete, move_valid, reject_code.
module move_check_engine
    import chess_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int PIECE_W = 4,
    parameter int MEM_LAT = 1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PIECE_W-1:0]   piece_to_move,
    input  logic [COORD_W-1:0]   origin_x,
    input  logic [COORD_W-1:0]   origin_y,
    input  logic [COORD_W-1:0]   destination_x,
    input  logic [COORD_W-1:0]   destination_y,
    input  logic [PIECE_W-1:0]   piece_read,
    output logic [2*COORD_W-1:0] address_validator,
    output logic                 busy,
    output logic                 validate_complete,
    output logic                 move_valid,
    output logic [2:0]           reject_code
);
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t               state, state_nxt;
    logic [PIECE_W-1:0]   req_piece, req_piece_nxt;
    logic [COORD_W-1:0]   req_ox, req_oy, req_tx, req_ty;
    logic [COORD_W-1:0]   req_ox_nxt, req_oy_nxt, req_tx_nxt, req_ty_nxt;
    logic [COORD_W-1:0]   remain, remain_nxt;
    logic [1:0]           lat_cnt, lat_cnt_nxt;
    logic [2*COORD_W-1:0] addr_nxt;
    logic                 busy_nxt, complete_nxt, valid_nxt;
    logic [2:0]           reject_nxt, dest_rej;

    logic                 null_req, legal;
    pawn_mode_t           pawn_mode;
    logic [1:0]           sx, sy;
    logic [COORD_W-1:0]   k, step_x, step_y, cur_x, cur_y;

    move_geometry #(.COORD_W(COORD_W), .PIECE_W(PIECE_W)) u_geom (
        .piece     (req_piece),
        .org_x     (req_ox),
        .org_y     (req_oy),
        .dst_x     (req_tx),
        .dst_y     (req_ty),
        .null_req  (null_req),
        .legal     (legal),
        .pawn_mode (pawn_mode),
        .sx        (sx),
        .sy        (sy),
        .k         (k)
    );

    assign step_x = COORD_W'($signed(sx));
    assign step_y = COORD_W'($signed(sy));
    assign cur_x  = address_validator[2*COORD_W-1:COORD_W];
    assign cur_y  = address_validator[COORD_W-1:0];

    // Verdict on the destination square's contents.
    always_comb begin
        dest_rej = REJ_OK;
        case (pawn_mode)
            PM_FWD1, PM_FWD2: if (piece_read != '0) dest_rej = REJ_BLOCK;
            PM_DIAG: begin
                if (piece_read == '0)                                          dest_rej = REJ_GEOM;
                else if (same_colour(int'(req_piece), int'(piece_read)))       dest_rej = REJ_FRIEND;
            end
            default:  if (same_colour(int'(req_piece), int'(piece_read)))      dest_rej = REJ_FRIEND;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        req_piece_nxt = req_piece;
        req_ox_nxt    = req_ox;
        req_oy_nxt    = req_oy;
        req_tx_nxt    = req_tx;
        req_ty_nxt    = req_ty;
        remain_nxt    = remain;
        lat_cnt_nxt   = lat_cnt;
        addr_nxt      = address_validator;
        busy_nxt      = busy;
        complete_nxt  = validate_complete;
        valid_nxt     = move_valid;
        reject_nxt    = reject_code;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt     = ST_DECODE;
                    req_piece_nxt = piece_to_move;
                    req_ox_nxt    = origin_x;
                    req_oy_nxt    = origin_y;
                    req_tx_nxt    = destination_x;
                    req_ty_nxt    = destination_y;
                    busy_nxt      = 1'b1;
                    complete_nxt  = 1'b0;
                    valid_nxt     = 1'b0;
                    reject_nxt    = REJ_OK;
                end
            end
            ST_DECODE: begin
                if (!legal) begin
                    state_nxt    = ST_DONE;
                    busy_nxt     = 1'b0;
                    complete_nxt = 1'b1;
                    reject_nxt   = null_req ? REJ_NULL : REJ_GEOM;
                end else begin
                    // Single-probe moves (knight, king, pawn fwd1/diag) go straight to the target.
                    state_nxt   = ST_PROBE;
                    remain_nxt  = k;
                    lat_cnt_nxt = '0;
                    addr_nxt    = (k == COORD_W'(1)) ? {req_tx, req_ty}
                                                     : {req_ox + step_x, req_oy + step_y};
                end
            end
            ST_PROBE: begin
                if (lat_cnt != LAT_LAST) begin
                    lat_cnt_nxt = lat_cnt + 2'd1;
                end else if (remain == COORD_W'(1)) begin
                    state_nxt    = ST_DONE;
                    addr_nxt     = '0;
                    busy_nxt     = 1'b0;
                    complete_nxt = 1'b1;
                    valid_nxt    = (dest_rej == REJ_OK);
                    reject_nxt   = dest_rej;
                end else if (piece_read != '0) begin
                    state_nxt    = ST_DONE;
                    addr_nxt     = '0;
                    busy_nxt     = 1'b0;
                    complete_nxt = 1'b1;
                    reject_nxt   = REJ_BLOCK;
                end else begin
                    remain_nxt  = remain - COORD_W'(1);
                    lat_cnt_nxt = '0;
                    addr_nxt    = {cur_x + step_x, cur_y + step_y};
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (abort && (state != ST_IDLE)) begin
            state_nxt    = ST_IDLE;
            addr_nxt     = '0;
            busy_nxt     = 1'b0;
            complete_nxt = 1'b0;
            valid_nxt    = 1'b0;
            reject_nxt   = REJ_OK;
        end else if (abort) begin
            state_nxt    = ST_IDLE;
            busy_nxt     = busy;
            complete_nxt = validate_complete;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            req_piece         <= '0;
            req_ox            <= '0;
            req_oy            <= '0;
            req_tx            <= '0;
            req_ty            <= '0;
            remain            <= '0;
            lat_cnt           <= '0;
            address_validator <= '0;
            busy              <= 1'b0;
            validate_complete <= 1'b0;
            move_valid        <= 1'b0;
            reject_code       <= REJ_OK;
        end else begin
            state             <= state_nxt;
            req_piece         <= req_piece_nxt;
            req_ox            <= req_ox_nxt;
            req_oy            <= req_oy_nxt;
            req_tx            <= req_tx_nxt;
            req_ty            <= req_ty_nxt;
            remain            <= remain_nxt;
            lat_cnt           <= lat_cnt_nxt;
            address_validator <= addr_nxt;
            busy              <= busy_nxt;
            validate_complete <= complete_nxt;
            move_valid        <= valid_nxt;
            reject_code       <= reject_nxt;
        end
    end

endmodule

// File: tb/tb_move_check_engine.sv
// Directed bench for move_check_engine: one instance at MEM_LAT=1, one at MEM_LAT=2,
// sharing a behavioural board RAM. Expected addresses, latencies and verdicts are hand-computed.
module tb_move_check_engine;

    logic       clk = 1'b0;
    logic       reset, abort, start1, start2;
    logic [3:0] piece;
    logic [2:0] ox, oy, tx, ty;
    logic [3:0] board [0:63];

    logic [5:0] addr1, addr2, o_addr;
    logic [3:0] rd1, rd2;
    logic       busy1, busy2, comp1, comp2, valid1, valid2;
    logic [2:0] rej1, rej2, o_rej;
    logic       o_busy, o_comp, o_valid;
    int         sel;

    int checks = 0, passes = 0, fails = 0;
    int tr[$];
    int exp_tr[$];
    int lat;

    always #5 clk = ~clk;

    assign rd1 = board[addr1];
    assign rd2 = board[addr2];

    assign o_addr  = (sel != 0) ? addr2  : addr1;
    assign o_busy  = (sel != 0) ? busy2  : busy1;
    assign o_comp  = (sel != 0) ? comp2  : comp1;
    assign o_valid = (sel != 0) ? valid2 : valid1;
    assign o_rej   = (sel != 0) ? rej2   : rej1;

    move_check_engine #(.COORD_W(3), .PIECE_W(4), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort),
        .piece_to_move(piece), .origin_x(ox), .origin_y(oy),
        .destination_x(tx), .destination_y(ty), .piece_read(rd1),
        .address_validator(addr1), .busy(busy1), .validate_complete(comp1),
        .move_valid(valid1), .reject_code(rej1)
    );

    move_check_engine #(.COORD_W(3), .PIECE_W(4), .MEM_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort),
        .piece_to_move(piece), .origin_x(ox), .origin_y(oy),
        .destination_x(tx), .destination_y(ty), .piece_read(rd2),
        .address_validator(addr2), .busy(busy2), .validate_complete(comp2),
        .move_valid(valid2), .reject_code(rej2)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
    endtask

    // Launch a check on instance s; record the probe address each cycle until complete.
    // At cycle restart_at a second start with a different request is pulsed (must be ignored).
    task automatic run(input int s, input int p, input int oxi, input int oyi,
                       input int txi, input int tyi, input int restart_at);
        sel   = s;
        piece = 4'(p);
        ox    = 3'(oxi);
        oy    = 3'(oyi);
        tx    = 3'(txi);
        ty    = 3'(tyi);
        if (s == 0) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        tr.delete();
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (o_comp) begin
                lat = c;
                break;
            end
            tr.push_back(int'(o_addr));
            if (c == restart_at) begin
                piece = 4'd6;
                ox    = 3'd7;
                tx    = 3'd6;
                if (s == 0) start1 = 1'b1; else start2 = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
        end
    endtask

    task automatic result(input string tag, input int exp_lat, input int exp_valid, input int exp_rej);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_valid"}, int'(o_valid), exp_valid);
        chk({tag, "_reject"}, int'(o_rej), exp_rej);
        chk({tag, "_busy_done"}, int'(o_busy), 0);
        chk({tag, "_addr_done"}, int'(o_addr), 0);
        chk({tag, "_trace_len"}, tr.size(), exp_tr.size());
        for (int i = 0; i < exp_tr.size() && i < tr.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), tr[i], exp_tr[i]);
    endtask

    initial begin
        int seen;
        reset  = 1'b1;
        abort  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        piece  = '0;
        ox = '0; oy = '0; tx = '0; ty = '0;
        sel = 0;
        clear_board();
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(addr1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_complete", int'(comp1), 0);
        chk("rst_valid", int'(valid1), 0);
        chk("rst_reject", int'(rej1), 0);
        chk("rst_addr2", int'(addr2), 0);
        reset = 1'b0;
        @(negedge clk);

        // Rook up the a-file on an empty board.
        exp_tr = '{0, 1, 2, 3};
        run(0, 4, 0, 0, 0, 3, -1);
        result("rook_clear", 4, 1, 0);

        // Bishop blocked at the first intermediate square.
        board[25] = 4'd7;
        exp_tr = '{0, 25};
        run(0, 3, 2, 0, 5, 3, -1);
        result("bishop_block", 2, 0, 3);
        clear_board();

        // Black knight onto a black bishop, then onto a white knight.
        board[21] = 4'd9;
        exp_tr = '{0, 21};
        run(0, 8, 1, 7, 2, 5, -1);
        result("knight_friend", 2, 0, 4);
        board[21] = 4'd2;
        run(0, 8, 1, 7, 2, 5, -1);
        result("knight_capture", 2, 1, 0);
        clear_board();

        // MEM_LAT=2: white pawn double step, each address held two cycles.
        exp_tr = '{0, 34, 34, 35, 35};
        run(1, 1, 4, 1, 4, 3, -1);
        result("pawn2_home", 5, 1, 0);
        exp_tr = '{0};
        run(1, 1, 4, 2, 4, 4, -1);
        result("pawn2_off_home", 1, 0, 2);

        // Null requests.
        exp_tr = '{0};
        run(0, 5, 3, 3, 3, 3, -1);
        result("queen_null", 1, 0, 1);
        run(0, 13, 0, 0, 0, 3, -1);
        result("bad_code", 1, 0, 1);

        // Pawn diagonal onto empty square, then onto an enemy.
        exp_tr = '{0, 42};
        run(0, 1, 4, 1, 5, 2, -1);
        result("pawn_diag_empty", 2, 0, 2);
        board[42] = 4'd7;
        run(0, 1, 4, 1, 5, 2, -1);
        result("pawn_diag_cap", 2, 1, 0);
        clear_board();

        // Pawn single step blocked; black pawn double step.
        board[34] = 4'd8;
        exp_tr = '{0, 34};
        run(0, 1, 4, 1, 4, 2, -1);
        result("pawn_fwd_block", 2, 0, 3);
        clear_board();
        exp_tr = '{0, 29, 28};
        run(0, 7, 3, 6, 3, 4, -1);
        result("bpawn2_home", 3, 1, 0);

        // Rook destination occupied by a friendly piece.
        board[3] = 4'd1;
        exp_tr = '{0, 1, 2, 3};
        run(0, 4, 0, 0, 0, 3, -1);
        result("rook_friend", 4, 0, 4);
        clear_board();

        // Start pulse while busy must not disturb the walk.
        run(0, 4, 0, 0, 0, 3, 1);
        result("start_busy", 4, 1, 0);

        // Abort mid-probe.
        sel = 0;
        piece = 4'd4; ox = 3'd0; oy = 3'd0; tx = 3'd0; ty = 3'd7;
        start1 = 1'b1;
        @(posedge clk); @(negedge clk);
        start1 = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("abort_pre_busy", int'(busy1), 1);
        abort = 1'b1;
        start1 = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        start1 = 1'b0;
        chk("abort_addr", int'(addr1), 0);
        chk("abort_busy", int'(busy1), 0);
        chk("abort_complete", int'(comp1), 0);
        chk("abort_reject", int'(rej1), 0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); @(negedge clk);
            if (comp1 || busy1) seen++;
        end
        chk("abort_quiet", seen, 0);

        // Reset mid-probe clears outputs asynchronously.
        start1 = 1'b1;
        @(posedge clk); @(negedge clk);
        start1 = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        #1;
        chk("rstmid_addr", int'(addr1), 0);
        chk("rstmid_busy", int'(busy1), 0);
        chk("rstmid_complete", int'(comp1), 0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); @(negedge clk);
            if (comp1 || busy1) seen++;
        end
        chk("rstmid_quiet", seen, 0);

        // Engine usable again after reset.
        exp_tr = '{0, 1, 2, 3};
        run(0, 4, 0, 0, 0, 3, -1);
        result("post_reset", 4, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
